// File: rtl/uart_tx_arbiter_if.sv
// Requester / UART_com handshake bundle for uart_tx_arbiter.
// slave = arbiter side, master = requesters plus transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 3
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_busy;
  logic                 trans_en;
  logic [7:0]           tx_data;
  logic [GW-1:0]        grant_id;
  logic                 active;
  logic                 timeout_err;

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  tx_busy,
    output req_ready,
    output trans_en,
    output tx_data,
    output grant_id,
    output active,
    output timeout_err
  );

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    output tx_busy,
    input  req_ready,
    input  trans_en,
    input  tx_data,
    input  grant_id,
    input  active,
    input  timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_com transmitter among NUM_REQ byte sources with burst lock.
// Define TX_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int BUSY_TIMEOUT = 1024
) (
  input logic              system_clock,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] winner;
  logic          win_ok;
  logic          lock;
  logic          xfer;
  logic          to_hit;
  logic [CW-1:0] cnt;
  logic [7:0]    data_q;
  logic          err_q;
  int            idx;
  int            base;

`ifdef TX_ARB_RR_EN
  logic [GW-1:0] rr_ptr;

  function automatic logic [GW-1:0] nxt(
    input logic [GW-1:0] x
  );
    return (x == GW'(NUM_REQ - 1)) ? '0 : x + 1'b1;
  endfunction
`endif

  // Under lock only the current grantee is eligible.
  always_comb begin
    winner = grant_q;
    win_ok = 1'b0;
    idx    = 0;
`ifdef TX_ARB_RR_EN
    base   = int'(rr_ptr);
`else
    base   = 0;
`endif
    if (lock) begin
      win_ok = bus.req_valid[grant_q];
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = base + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!win_ok && bus.req_valid[idx]) begin
          winner = GW'(idx);
          win_ok = 1'b1;
        end
      end
    end
  end

  assign xfer   = (state == IDLE) && win_ok;
  assign to_hit = (state == WAIT_BUSY) && !bus.tx_busy
               && (cnt >= CW'(BUSY_TIMEOUT - 1));

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (win_ok) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy)  state_nxt = WAIT_DONE;
        else if (to_hit)  state_nxt = IDLE;
      end
      WAIT_DONE: if (!bus.tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Ready is masked during reset so no byte appears accepted.
  always_comb begin
    bus.trans_en  = (state == LAUNCH);
    bus.req_ready = '0;
    if (xfer && !reset) bus.req_ready[winner] = 1'b1;
  end

  assign bus.tx_data     = data_q;
  assign bus.grant_id    = grant_q;
  assign bus.timeout_err = err_q;
  assign bus.active      = (state != IDLE) || lock;

  // Counter runs from LAUNCH so the error lands BUSY_TIMEOUT after trans_en.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      grant_q <= '0;
      lock    <= 1'b0;
      cnt     <= '0;
      err_q   <= 1'b0;
`ifdef TX_ARB_RR_EN
      rr_ptr  <= '0;
`endif
    end else begin
      if (xfer) begin
        data_q  <= bus.req_data[int'(winner)*8 +: 8];
        grant_q <= winner;
        lock    <= ~bus.req_last[winner];
      end
      if (xfer) begin
        cnt <= '0;
      end else if ((state == LAUNCH || state == WAIT_BUSY)
                   && cnt != CW'(BUSY_TIMEOUT)) begin
        cnt <= cnt + 1'b1;
      end
      if (to_hit) begin
        err_q <= 1'b1;
        lock  <= 1'b0;
      end
`ifdef TX_ARB_RR_EN
      if (xfer && bus.req_last[winner]) rr_ptr <= nxt(winner);
      else if (to_hit)                  rr_ptr <= nxt(grant_q);
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter.
// Expected launches are queued with stimulus and popped on trans_en.
module tb_uart_tx_arbiter;
`ifdef TX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(3)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(3),
    .BUSY_TIMEOUT(16)
  ) dut (
    .system_clock(clk),
    .reset(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [8:0] rq [3][$];
  logic [9:0] exp_q[$];
  int         te_q[$];
  logic [2:0] acc;

  int busy_delay = 1;
  int busy_len   = 5;
  bit busy_never = 1'b0;
  int m_dly      = 0;
  int m_len      = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  // Requesters: present queue heads, retire on accepted transfer.
  always @(posedge clk) acc <= bus.req_valid & bus.req_ready;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (acc[i] === 1'b1 && rq[i].size() > 0) void'(rq[i].pop_front());
      if (rq[i].size() > 0) begin
        bus.req_valid[i]        = 1'b1;
        bus.req_data[i*8 +: 8]  = rq[i][0][7:0];
        bus.req_last[i]         = rq[i][0][8];
      end else begin
        bus.req_valid[i]        = 1'b0;
        bus.req_data[i*8 +: 8]  = 8'h00;
        bus.req_last[i]         = 1'b0;
      end
    end
  end

  // UART_com model: busy rises busy_delay after trans_en for busy_len.
  always @(negedge clk) begin
    if (rst) begin
      m_dly = 0;
      m_len = 0;
      bus.tx_busy = 1'b0;
    end else if (m_dly > 0) begin
      m_dly--;
      if (m_dly == 0) begin
        bus.tx_busy = 1'b1;
        m_len = busy_len;
      end
    end else if (m_len > 0) begin
      m_len--;
      if (m_len == 0) bus.tx_busy = 1'b0;
    end else if (bus.trans_en && !busy_never) begin
      if (busy_delay == 0) begin
        bus.tx_busy = 1'b1;
        m_len = busy_len;
      end else begin
        m_dly = busy_delay;
      end
    end
  end

  // Scoreboard: each launch must match the next queued grant/byte.
  always @(negedge clk) begin
    logic [9:0] e;
    if (bus.trans_en === 1'b1) begin
      te_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_launch", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("launch_id", 32'(bus.grant_id), 32'(e[9:8]));
        chk("launch_data", 32'(bus.tx_data), 32'(e[7:0]));
      end
    end
  end

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || rq[0].size() != 0 ||
            rq[1].size() != 0 || rq[2].size() != 0 ||
            bus.active || bus.tx_busy) && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_drain"}, 32'(n < 300), 32'd1);
  endtask

  initial begin
    int t0;
    int t1;
    int viol;

    repeat (2) step();
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_trans_en", 32'(bus.trans_en), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_grant", 32'(bus.grant_id), 32'd0);
    chk("rst_active", 32'(bus.active), 32'd0);
    chk("rst_err", 32'(bus.timeout_err), 32'd0);
    rst = 1'b0;
    step();

    // Single byte from requester 1
    busy_delay = 1;
    busy_len   = 5;
    exp_q.push_back({2'd1, 8'hA5});
    rq[1].push_back({1'b1, 8'hA5});
    step();
    chk("t1_ready", 32'(bus.req_ready), 32'b010);
    chk("t1_no_launch_yet", 32'(bus.trans_en), 32'd0);
    step();
    chk("t1_trans_en", 32'(bus.trans_en), 32'd1);
    chk("t1_tx_data", 32'(bus.tx_data), 32'hA5);
    drain("t1");
    chk("t1_active", 32'(bus.active), 32'd0);
    chk("t1_hold", 32'(bus.tx_data), 32'hA5);

    // Contention between requesters 0 and 2
    if (RR) begin
      exp_q.push_back({2'd2, 8'h22});
      exp_q.push_back({2'd0, 8'h11});
    end else begin
      exp_q.push_back({2'd0, 8'h11});
      exp_q.push_back({2'd2, 8'h22});
    end
    rq[0].push_back({1'b1, 8'h11});
    rq[2].push_back({1'b1, 8'h22});
    step();
    chk("t2_onehot", 32'(bus.req_ready), RR ? 32'b100 : 32'b001);
    drain("t2");

    // Burst lock: requester 2 holds the UART for three bytes
    exp_q.push_back({2'd2, 8'h31});
    exp_q.push_back({2'd2, 8'h32});
    exp_q.push_back({2'd2, 8'h33});
    exp_q.push_back({2'd0, 8'h44});
    rq[2].push_back({1'b0, 8'h31});
    rq[2].push_back({1'b0, 8'h32});
    rq[2].push_back({1'b1, 8'h33});
    step();
    chk("t3_first", 32'(bus.req_ready), 32'b100);
    rq[0].push_back({1'b1, 8'h44});
    viol = 0;
    for (int n = 0; n < 200 && exp_q.size() > 1; n++) begin
      step();
      if (bus.req_valid[0] && bus.req_ready[0]) viol++;
    end
    chk("t3_locked_out", 32'(viol), 32'd0);
    drain("t3");

    // Busy never rises: sticky error, lock dropped, next grant
    busy_never = 1'b1;
    exp_q.push_back({2'd1, 8'h55});
    exp_q.push_back({2'd2, 8'h66});
    rq[1].push_back({1'b1, 8'h55});
    rq[2].push_back({1'b1, 8'h66});
    t0 = -1;
    t1 = -1;
    for (int n = 0; n < 100; n++) begin
      step();
      if (t0 < 0 && bus.trans_en) t0 = cyc;
      if (bus.timeout_err) begin
        t1 = cyc;
        break;
      end
    end
    chk("t4_latency", 32'(t1 - t0), 32'd16);
    chk("t4_released", 32'(bus.active), 32'd0);
    busy_never = 1'b0;
    drain("t4");
    chk("t4_sticky", 32'(bus.timeout_err), 32'd1);

    // Reset while a byte is in WAIT_DONE
    busy_len = 8;
    exp_q.push_back({2'd2, 8'h77});
    rq[2].push_back({1'b0, 8'h77});
    rq[2].push_back({1'b1, 8'h78});
    for (int n = 0; n < 50 && !bus.tx_busy; n++) step();
    step();
    chk("t5_in_flight", 32'(bus.active), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_ready", 32'(bus.req_ready), 32'd0);
    chk("t5_trans_en", 32'(bus.trans_en), 32'd0);
    chk("t5_tx_data", 32'(bus.tx_data), 32'd0);
    chk("t5_grant", 32'(bus.grant_id), 32'd0);
    chk("t5_active", 32'(bus.active), 32'd0);
    chk("t5_err", 32'(bus.timeout_err), 32'd0);
    rq[0].push_back({1'b1, 8'h99});
    exp_q.push_back({2'd0, 8'h99});
    exp_q.push_back({2'd2, 8'h78});
    busy_len = 2;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("t5_no_lock", 32'(bus.req_ready), 32'b001);
    drain("t5");

    // Back-to-back burst from requester 1
    te_q.delete();
    busy_delay = 1;
    busy_len   = 2;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({2'd1, 8'(8'hC0 + k)});
      rq[1].push_back({k == 3, 8'(8'hC0 + k)});
    end
    drain("t6");
    chk("t6_pulses", 32'(te_q.size()), 32'd4);
    for (int k = 1; k < te_q.size(); k++) begin
      chk("t6_gap", 32'(te_q[k] - te_q[k-1] >= 4), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
